// File: rtl/radio_timing_sequencer_pkg.sv
// Shared types and defaults for the radio timing engine.
// The top-level sequencer and the synchroniser both import this package.
package pa_TimingEngine;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLL_WAIT = 3'd1,
    ARST     = 3'd2,
    ACTIVE   = 3'd3,
    ERROR    = 3'd4
  } te_state_t;

  localparam int DEF_SYNC_STAGES        = 2;
  localparam int DEF_PLL_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/radio_timing_sequencer_sync.sv
// Single-bit flop-chain synchroniser for an asynchronous request.
// The chain clears synchronously on reset.
import pa_TimingEngine::*;

module te_sync_bit #(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], async_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign sync_out = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/radio_timing_sequencer.sv
// Radio power-up sequencer: PLL wait, fast-settle window, then radio enable.
// Outputs are decoded from the registered state only.
import pa_TimingEngine::*;

module radio_timing_sequencer #(
  parameter int SIZE_SPISLAVE_T_ARSTFS = 1,
  parameter int SYNC_STAGES            = DEF_SYNC_STAGES,
  parameter int PLL_TIMEOUT_CYCLES     = DEF_PLL_TIMEOUT_CYCLES
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              radioEnableUnsynced,
  input  logic                              radioRxEnUnsynced,
  input  logic                              pllSettled,
  input  logic [SIZE_SPISLAVE_T_ARSTFS-1:0] tArstFs,
  output logic                              radioEnableSynced,
  output logic                              radioRxEnSynced,
  output logic                              pllEnable,
  output logic                              arstFs,
  output logic                              radioEnable,
  output logic                              radioRxEn,
  output logic                              pllTimeout
);

  localparam int TW = $clog2(PLL_TIMEOUT_CYCLES + 1);
  localparam int CW = SIZE_SPISLAVE_T_ARSTFS;

  te_state_t     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] counter_q, counter_d;
  logic          en_s;
  logic          rx_s;

  te_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
    .clk      (clk),
    .reset    (reset),
    .async_in (radioEnableUnsynced),
    .sync_out (en_s)
  );

  te_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rx (
    .clk      (clk),
    .reset    (reset),
    .async_in (radioRxEnUnsynced),
    .sync_out (rx_s)
  );

  // Priority in every busy state: request withdrawn, PLL lost, progress, timeout.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    counter_d = counter_q;
    case (state_q)
      IDLE: begin
        if (en_s) begin
          state_d = PLL_WAIT;
          timer_d = '0;
        end
      end
      PLL_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (!en_s) begin
          state_d = IDLE;
        end else if (pllSettled) begin
          if (tArstFs == '0) begin
            state_d = ACTIVE;
          end else begin
            state_d   = ARST;
            counter_d = tArstFs;
          end
        end else if (timer_q == TW'(PLL_TIMEOUT_CYCLES - 1)) begin
          state_d = ERROR;
          timer_d = timer_q;
        end
      end
      ARST: begin
        counter_d = counter_q - CW'(1);
        if (!en_s) begin
          state_d = IDLE;
        end else if (!pllSettled) begin
          state_d = PLL_WAIT;
          timer_d = '0;
        end else if (counter_q == CW'(1)) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!en_s) begin
          state_d = IDLE;
        end else if (!pllSettled) begin
          state_d = PLL_WAIT;
          timer_d = '0;
        end
      end
      ERROR: begin
        if (!en_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      counter_q <= counter_d;
    end
  end

  assign radioEnableSynced = en_s;
  assign radioRxEnSynced   = rx_s;
  assign pllEnable   = (state_q == PLL_WAIT) || (state_q == ARST) || (state_q == ACTIVE);
  assign arstFs      = (state_q == ARST);
  assign radioEnable = (state_q == ACTIVE);
  assign radioRxEn   = (state_q == ACTIVE) && rx_s;
  assign pllTimeout  = (state_q == ERROR);

endmodule

// File: tb/tb_radio_timing_sequencer.sv
// Scoreboard bench: a driver pushes expected outputs from a behavioural model,
// a monitor pops and compares them one cycle later.
module tb_radio_timing_sequencer;

  localparam int SIZE    = 2;
  localparam int SYNC    = 2;
  localparam int TIMEOUT = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            radioEnableUnsynced = 1'b0;
  logic            radioRxEnUnsynced = 1'b0;
  logic            pllSettled = 1'b0;
  logic [SIZE-1:0] tArstFs = '0;
  logic            radioEnableSynced, radioRxEnSynced, pllEnable, arstFs;
  logic            radioEnable, radioRxEn, pllTimeout;

  radio_timing_sequencer #(
    .SIZE_SPISLAVE_T_ARSTFS (SIZE),
    .SYNC_STAGES            (SYNC),
    .PLL_TIMEOUT_CYCLES     (TIMEOUT)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .radioEnableUnsynced (radioEnableUnsynced),
    .radioRxEnUnsynced   (radioRxEnUnsynced),
    .pllSettled          (pllSettled),
    .tArstFs             (tArstFs),
    .radioEnableSynced   (radioEnableSynced),
    .radioRxEnSynced     (radioRxEnSynced),
    .pllEnable           (pllEnable),
    .arstFs              (arstFs),
    .radioEnable         (radioEnable),
    .radioRxEn           (radioRxEn),
    .pllTimeout          (pllTimeout)
  );

  always #5 clk = ~clk;

  // Expected vector: {enS, rxS, pllEnable, arstFs, radioEnable, radioRxEn, pllTimeout}
  logic [6:0] exp_q[$];
  int n_compared = 0;
  int n_mismatch = 0;
  int n_cycle    = 0;

  // Behavioural model: the radio "mode" plus how long it has been there.
  localparam int M_OFF = 0, M_WAITPLL = 1, M_SETTLE = 2, M_ON = 3, M_FAULT = 4;
  bit m_en_pipe[SYNC];
  bit m_rx_pipe[SYNC];
  int m_mode;
  int m_waited;
  int m_settle_left;

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) begin
      m_en_pipe[i] = 1'b0;
      m_rx_pipe[i] = 1'b0;
    end
    m_mode = M_OFF;
    m_waited = 0;
    m_settle_left = 0;
  endtask

  task automatic model_step(input bit rst, input bit en, input bit rx,
                            input bit pll, input int t);
    bit req;
    if (rst) begin
      model_reset();
      return;
    end
    req = m_en_pipe[SYNC-1];
    if (m_mode != M_OFF && !req) begin
      m_mode = M_OFF;
    end else begin
      case (m_mode)
        M_OFF: if (req) begin m_mode = M_WAITPLL; m_waited = 0; end
        M_WAITPLL: begin
          if (pll) begin
            if (t == 0) m_mode = M_ON;
            else begin m_mode = M_SETTLE; m_settle_left = t; end
          end else if (m_waited + 1 >= TIMEOUT) m_mode = M_FAULT;
          else m_waited++;
        end
        M_SETTLE: begin
          if (!pll) begin m_mode = M_WAITPLL; m_waited = 0; end
          else if (m_settle_left == 1) m_mode = M_ON;
          else m_settle_left--;
        end
        M_ON: if (!pll) begin m_mode = M_WAITPLL; m_waited = 0; end
        default: ;
      endcase
    end
    for (int i = SYNC - 1; i > 0; i--) begin
      m_en_pipe[i] = m_en_pipe[i-1];
      m_rx_pipe[i] = m_rx_pipe[i-1];
    end
    m_en_pipe[0] = en;
    m_rx_pipe[0] = rx;
  endtask

  function automatic logic [6:0] model_out();
    bit ens = m_en_pipe[SYNC-1];
    bit rxs = m_rx_pipe[SYNC-1];
    bit on  = (m_mode == M_ON);
    bit pwr = (m_mode == M_WAITPLL) || (m_mode == M_SETTLE) || on;
    return {ens, rxs, pwr, (m_mode == M_SETTLE), on, on && rxs, (m_mode == M_FAULT)};
  endfunction

  task automatic cyc(input bit rst, input bit en, input bit rx,
                     input bit pll, input int t);
    int tm;
    tm = t % (1 << SIZE);
    @(negedge clk);
    reset               = rst;
    radioEnableUnsynced = en;
    radioRxEnUnsynced   = rx;
    pllSettled          = pll;
    tArstFs             = tm[SIZE-1:0];
    model_step(rst, en, rx, pll, tm);
    exp_q.push_back(model_out());
    n_cycle++;
  endtask

  task automatic hold(input int n, input bit rst, input bit en, input bit rx,
                      input bit pll, input int t);
    for (int i = 0; i < n; i++) cyc(rst, en, rx, pll, t);
  endtask

  // Monitor: the DUT presents a full output vector after every edge.
  initial begin
    logic [6:0] act, exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act = {radioEnableSynced, radioRxEnSynced, pllEnable, arstFs,
               radioEnable, radioRxEn, pllTimeout};
        n_compared++;
        if (act !== exp_v) begin
          n_mismatch++;
          $display("FAIL outputs t=%0t got=%b expected=%b (enS rxS pllEn arst en rxEn tmo)",
                   $time, act, exp_v);
        end
      end
    end
  end

  initial begin
    int mode, len, t;
    bit en, rx, pll;
    model_reset();

    $display("seg reset");
    hold(3, 1, 0, 0, 0, 0);
    $display("seg nominal tArstFs=3, PLL settles late");
    hold(8, 0, 1, 1, 0, 3);
    hold(10, 0, 1, 1, 1, 3);
    $display("seg rx toggle in ACTIVE");
    hold(3, 0, 1, 0, 1, 3);
    hold(3, 0, 1, 1, 1, 3);
    $display("seg pll loss and recovery");
    hold(1, 0, 1, 1, 0, 3);
    hold(8, 0, 1, 1, 1, 3);
    $display("seg reset while ACTIVE");
    hold(1, 1, 1, 1, 1, 3);
    hold(2, 0, 0, 0, 1, 0);
    $display("seg skip fast-settle");
    hold(8, 0, 1, 1, 1, 0);
    hold(5, 0, 0, 0, 1, 0);
    $display("seg PLL timeout");
    hold(15, 0, 1, 0, 0, 2);
    hold(5, 0, 0, 0, 0, 2);
    $display("seg abort during fast-settle");
    hold(4, 0, 1, 1, 1, 3);
    hold(5, 0, 0, 1, 1, 3);
    $display("seg max window with tArstFs change mid-window");
    hold(4, 0, 1, 1, 1, 3);
    hold(6, 0, 1, 1, 1, 1);
    hold(4, 0, 0, 0, 1, 1);

    for (int s = 0; s < 60; s++) begin
      mode = $urandom_range(0, 3);
      len  = $urandom_range(10, 60);
      t    = $urandom_range(0, 3);
      en   = 1'b1;
      rx   = $urandom_range(0, 1);
      pll  = (mode != 0);
      $display("seg random %0d mode=%0d len=%0d tArstFs=%0d", s, mode, len, t);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 29) == 0) en = ~en;
        if ($urandom_range(0, 5) == 0) rx = ~rx;
        if (mode == 2 && $urandom_range(0, 6) == 0) pll = ~pll;
        if (mode == 3 && $urandom_range(0, 3) == 0) pll = $urandom_range(0, 1);
        if ($urandom_range(0, 9) == 0) t = $urandom_range(0, 3);
        cyc(($urandom_range(0, 199) == 0), en, rx, pll, t);
      end
      hold($urandom_range(1, 4), 0, 0, rx, pll, t);
    end

    @(posedge clk);
    #3;
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatch++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/radio_timing_sequencer.md
Name: radio_timing_sequencer

Overview:
- Control FSM that drives the radio timing engine.
- Synchronises the asynchronous radio enable and RX-enable requests into the clk domain.
- Powers up the PLL and waits for pllSettled, then applies a fast-settle (ARSTFS) window of tArstFs cycles before asserting radioEnable and radioRxEn.
- Sits between the SPI slave register bank (tArstFs, request bits) and the radio analog front end.

Parameters:
SIZE_SPISLAVE_T_ARSTFS, 1, width of the tArstFs fast-settle count input
SYNC_STAGES, 2, number of synchroniser flops per asynchronous request (minimum 2)
PLL_TIMEOUT_CYCLES, 255, cycles allowed in PLL_WAIT before declaring a PLL timeout

Ports:
clk  input  1  system clock; single clock domain
reset  input  1  synchronous, active-high reset
radioEnableUnsynced  input  1  asynchronous radio enable request
radioRxEnUnsynced  input  1  asynchronous RX-mode request
pllSettled  input  1  PLL lock indication, already in the clk domain
tArstFs  input  SIZE_SPISLAVE_T_ARSTFS  fast-settle duration in cycles
radioEnableSynced  output  1  final synchroniser stage of radioEnableUnsynced
radioRxEnSynced  output  1  final synchroniser stage of radioRxEnUnsynced
pllEnable  output  1  PLL power-up request
arstFs  output  1  fast-settle strobe to the analog front end
radioEnable  output  1  radio enabled
radioRxEn  output  1  radio in RX mode (only ever high while radioEnable is high)
pllTimeout  output  1  PLL failed to settle; held until request is withdrawn

Behaviour:
- Reset: all synchroniser flops are 0, the FSM is in IDLE, the timer and counter are 0, and every output is 0. Reset asserted mid-operation returns the block to IDLE on the next edge.
- Synchronisers: a SYNC_STAGES-deep flop chain per request. enS/rxS denote radioEnableSynced/radioRxEnSynced.
- Outputs are decoded from the registered state (Moore). Output values by state:
  - pllEnable = 1 in PLL_WAIT, ARST and ACTIVE.
  - arstFs = 1 only in ARST.
  - radioEnable = 1 only in ACTIVE.
  - radioRxEn = (state==ACTIVE) & rxS.
  - pllTimeout = 1 only in ERROR.
- Transition priority in every non-IDLE state: enS=0 first, then loss of pllSettled, then forward progress, then timeout.
- FSM states and transitions:
  - IDLE: enS=1 -> PLL_WAIT; timer cleared.
  - PLL_WAIT: timer increments each cycle.
    - enS=0 -> IDLE.
    - pllSettled=1 with tArstFs==0 -> ACTIVE; the ARST phase is skipped.
    - pllSettled=1 with tArstFs!=0 -> ARST; counter loaded with tArstFs.
    - Otherwise, timer==PLL_TIMEOUT_CYCLES-1 -> ERROR.
    - If pllSettled and the timeout coincide, pllSettled wins.
  - ARST: counter decrements each cycle.
    - enS=0 -> IDLE.
    - pllSettled=0 -> PLL_WAIT; timer cleared.
    - counter==1 -> ACTIVE, so arstFs is high for exactly tArstFs cycles.
    - tArstFs is sampled only on entry; later changes are ignored until the next entry.
  - ACTIVE:
    - enS=0 -> IDLE.
    - pllSettled=0 -> PLL_WAIT; radioEnable drops the next cycle and the timer is cleared.
    - rxS may toggle freely; radioRxEn follows it with zero added latency.
  - ERROR: pllEnable=0. Stays until enS=0 -> IDLE. A fresh rising request is required to retry.
- Latency (IDLE, PLL already settled, tArstFs=N>0): radioEnableUnsynced rising -> enS high after SYNC_STAGES edges -> PLL_WAIT +1 -> ARST +1 -> ACTIVE +N.
- Widths:
  - Timer is $clog2(PLL_TIMEOUT_CYCLES+1) bits and never wraps; it saturates via the ERROR transition.
  - Counter is SIZE_SPISLAVE_T_ARSTFS bits; maximum window is 2^SIZE-1 cycles.

Decomposition:
- Package pa_TimingEngine holds:
  - typedef enum logic [2:0] te_state_t {IDLE, PLL_WAIT, ARST, ACTIVE, ERROR};
  - default constants for SYNC_STAGES and PLL_TIMEOUT_CYCLES.
- Sub-module te_sync_bit: parameterised SYNC_STAGES flop chain with synchronous reset, instantiated twice (enable and rxEn).
- The FSM, timer and counter stay in radio_timing_sequencer.

Test Plan:
- Nominal: SYNC_STAGES=2, tArstFs=3, pllSettled rises 5 cycles after PLL_WAIT entry, enable and rxEn high -> arstFs high exactly 3 cycles, then radioEnable=1 and radioRxEn=1 together; pllTimeout stays 0.
- Skip fast-settle: tArstFs=0, pllSettled already high -> PLL_WAIT one cycle, then ACTIVE directly; arstFs never asserts.
- Timeout: PLL_TIMEOUT_CYCLES=8, pllSettled held 0 -> pllTimeout=1 after exactly 8 PLL_WAIT cycles and pllEnable=0; dropping enable -> IDLE with pllTimeout=0.
- PLL loss: in ACTIVE, pllSettled=0 for 1 cycle -> radioEnable=0 next cycle, state PLL_WAIT; on return, the full ARST window of tArstFs repeats.
- Abort/reset: drop enable during ARST (counter=2) -> all outputs 0 within SYNC_STAGES+1 cycles. Separately, assert reset in ACTIVE -> all outputs 0 on the next edge.
- RX toggle: in ACTIVE, toggle radioRxEnUnsynced 1->0->1 -> radioRxEn tracks rxS; radioEnable stays 1 throughout.
